frame_buf: RTL

//  Double-buffered frame store directly upstream of the HUB75 display controller.

---
 rtl/frame_buf.sv | 120 ++++++++++++
 1 files changed

// File: rtl/frame_buf.sv
// Double-buffered 64x32 RGB frame store feeding a HUB75 controller.
// Renderer writes the back bank; banks flip only at the controller's frame rollover.
module frame_buf #(
    parameter int COLS  = 64,
    parameter int ROWS  = 16,
    parameter int PIX_W = 12
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wr_valid,
    output logic                                  wr_ready,
    input  logic [$clog2(COLS)-1:0]               wr_x,
    input  logic [$clog2(ROWS):0]                 wr_y,
    input  logic [PIX_W-1:0]                      wr_rgb,
    input  logic                                  frame_done,
    input  logic [$clog2(COLS)+$clog2(ROWS)-1:0]  r_addr,
    output logic [PIX_W-1:0]                      din_top,
    output logic [PIX_W-1:0]                      din_btm,
    output logic                                  front_bank,
    output logic                                  swapped
);
    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int AW    = CW + RW;
    localparam int DEPTH = COLS * ROWS;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {S_CLEAR, S_FILL, S_PEND} state_t;

    state_t              r_state;
    logic [AW-1:0]       r_clr_cnt;
    logic [AW-1:0]       r_raddr_q;
    logic                r_front;
    logic                r_wr_ready;
    logic                r_swapped;
    logic [PIX_W-1:0]    r_din_top;
    logic [PIX_W-1:0]    r_din_btm;

    // RAM index is {bank, half}: 0/1 = bank 0 top/btm, 2/3 = bank 1 top/btm
    logic [PIX_W-1:0]    r_mem [4][DEPTH];

    logic [AW-1:0]       w_waddr;
    logic                w_wr;
    logic                w_clr;
    logic                w_wrap;
    logic [1:0]          w_wsel;

    assign w_waddr = {wr_y[RW-1:0], wr_x};
    assign w_wsel  = {~r_front, wr_y[RW]};
    assign w_wr    = wr_valid & r_wr_ready;
    assign w_clr   = (r_state == S_CLEAR);
    assign w_wrap  = (r_raddr_q == LAST) && (r_addr == '0);

    assign wr_ready   = r_wr_ready;
    assign swapped    = r_swapped;
    assign front_bank = r_front;
    assign din_top    = r_din_top;
    assign din_btm    = r_din_btm;

    always_ff @(posedge clk) begin
        if (w_clr) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i][r_clr_cnt] <= '0;
            end
        end else if (w_wr) begin
            r_mem[w_wsel][w_waddr] <= wr_rgb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_CLEAR;
            r_clr_cnt  <= '0;
            r_raddr_q  <= '0;
            r_front    <= 1'b0;
            r_wr_ready <= 1'b0;
            r_swapped  <= 1'b0;
            r_din_top  <= '0;
            r_din_btm  <= '0;
        end else begin
            r_raddr_q <= r_addr;
            r_swapped <= 1'b0;
            if (w_clr) begin
                r_din_top <= '0;
                r_din_btm <= '0;
            end else begin
                r_din_top <= r_mem[{r_front, 1'b0}][r_addr];
                r_din_btm <= r_mem[{r_front, 1'b1}][r_addr];
            end
            case (r_state)
                S_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == LAST) begin
                        r_state    <= S_FILL;
                        r_wr_ready <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (frame_done) begin
                        r_state    <= S_PEND;
                        r_wr_ready <= 1'b0;
                    end
                end
                S_PEND: begin
                    // Flip only on the row 15 -> row 0 rollover so the panel never shows a torn frame
                    if (w_wrap) begin
                        r_front    <= ~r_front;
                        r_swapped  <= 1'b1;
                        r_state    <= S_FILL;
                        r_wr_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_CLEAR;
                    r_wr_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule
